prop_hold_src: RTL

//   Stimulus-side transmitter for capture-and-compare checked interfaces.
//   It accepts words from an upstream valid/ready port, buffers them, and drives a

---
 rtl/prop_hold_pkg.sv | 12 +
 rtl/prop_hold_fifo.sv | 54 +++++
 rtl/prop_hold_src.sv | 122 ++++++++++++
 3 files changed

// File: rtl/prop_hold_pkg.sv
// Shared types and constants for the hold-window stimulus source.
package prop_hold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } hold_state_t;

    localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/prop_hold_fifo.sv
// Synchronous FIFO with registered occupancy count and combinational head read.
module prop_hold_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/prop_hold_src.sv
// Buffers upstream words and launches each as a one-cycle strobe, then holds
// the data stable for HOLD_CYCLES cycles before the next launch may occur.
module prop_hold_src
    import prop_hold_pkg::*;
#(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [15:0]   beats
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD =
        (HOLD_CYCLES == 0) ? '0 : HOLD_CNT_W'(HOLD_CYCLES - 1);

    hold_state_t           state;
    hold_state_t           state_n;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [HOLD_CNT_W-1:0] hold_cnt_n;
    logic                  push;
    logic                  pop;
    logic [DW-1:0]         fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DW-1:0]         out_data_q;
    logic [15:0]           beat_q;

    assign push = in_valid & ~fifo_full;

    prop_hold_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    // Every pop is a launch: the popped word becomes out_data as SEND is entered.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (HOLD_CYCLES != 0) begin
                    hold_cnt_n = HOLD_RELOAD;
                    state_n    = HOLD;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = SEND;
                end else begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_cnt_n = hold_cnt - HOLD_CNT_W'(1);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = SEND;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            beat_q     <= '0;
        end else begin
            if (pop) begin
                out_data_q <= fifo_rdata;
            end
            if (out_valid) begin
                beat_q <= beat_q + 16'd1;
            end
        end
    end

    assign out_valid = (state == SEND);
    assign out_data  = out_data_q;
    assign beats     = beat_q;
    assign in_ready  = ~fifo_full;
    assign busy      = (fifo_count != '0) | (state != IDLE);

endmodule
